// File: rtl/ir_nec_tx.sv
// rtl/ir_nec_tx.sv - NEC IR transmitter (leader, 32 pulse-distance bits, stop, gap); carrier via IR_TX_CARRIER_EN
module ir_nec_tx #(
    parameter int UNIT_CYCLES  = 1170,
    parameter int CARRIER_HALF = 27,
    parameter int GAP_UNITS    = 72
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] address,
    input  logic [7:0] command,
    output logic       busy,
    output logic       done,
    output logic       ir_out
);

    localparam int TW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    // Unit count is 7 bits wide, so the gap must fit in it.
    if (UNIT_CYCLES < 1 || CARRIER_HALF < 1 || GAP_UNITS < 1 || GAP_UNITS > 127) begin : g_bad_params
        $error("ir_nec_tx: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    function automatic logic is_mark(input state_t s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [6:0]    units_q, units_d;
    logic [4:0]    idx_q, idx_d;
    logic [31:0]   shift_q, shift_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ir_out_q, ir_out_d;
    logic          mark_d;
    logic          unit_tick;
    logic          last_unit;
    logic [6:0]    dur;

    // Sequencer: state durations in units, bit shifting, unit timer restart on every state change.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        units_d   = units_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        unit_tick = (timer_q == TW'(UNIT_CYCLES - 1));
        case (state_q)
            LEAD_MARK:  dur = 7'd16;
            LEAD_SPACE: dur = 7'd8;
            BIT_SPACE:  dur = shift_q[31] ? 7'd3 : 7'd1;
            GAP:        dur = 7'(GAP_UNITS);
            default:    dur = 7'd1;
        endcase
        last_unit = unit_tick && (units_q == dur - 7'd1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = {address, ~address, command, ~command};
                    state_d = LEAD_MARK;
                end
            end
            LEAD_MARK:  if (last_unit) state_d = LEAD_SPACE;
            LEAD_SPACE: begin
                if (last_unit) begin
                    state_d = BIT_MARK;
                    idx_d   = 5'd31;
                end
            end
            BIT_MARK:   if (last_unit) state_d = BIT_SPACE;
            BIT_SPACE: begin
                if (last_unit) begin
                    shift_d = {shift_q[30:0], 1'b0};
                    idx_d   = idx_q - 5'd1;
                    state_d = (idx_q == 5'd0) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK:  if (last_unit) state_d = GAP;
            GAP: begin
                if (last_unit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default:    state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
            units_d = '0;
        end else if (state_q != IDLE) begin
            if (unit_tick) begin
                timer_d = '0;
                units_d = units_q + 7'd1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        busy_d = (state_d != IDLE);
        mark_d = is_mark(state_d);
    end

`ifdef IR_TX_CARRIER_EN
    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    logic [CW-1:0] car_q, car_d;
    logic          phase_q, phase_d;

    // Carrier restarts high at each mark entry and toggles every CARRIER_HALF cycles.
    always_comb begin
        car_d   = car_q;
        phase_d = phase_q;
        if (mark_d && !is_mark(state_q)) begin
            car_d   = '0;
            phase_d = 1'b1;
        end else if (mark_d) begin
            if (car_q == CW'(CARRIER_HALF - 1)) begin
                car_d   = '0;
                phase_d = ~phase_q;
            end else begin
                car_d = car_q + CW'(1);
            end
        end else begin
            car_d   = '0;
            phase_d = 1'b0;
        end
        ir_out_d = mark_d & phase_d;
    end

    // Carrier counter and phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            car_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            car_q   <= car_d;
            phase_q <= phase_d;
        end
    end
`else
    // Envelope output: LED on for the whole of every mark.
    always_comb begin
        ir_out_d = mark_d;
    end
`endif

    // Main state and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            units_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ir_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            units_q  <= units_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ir_out_q <= ir_out_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ir_out = ir_out_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// tb/tb_ir_nec_tx.sv - randomized self-checking bench for ir_nec_tx
module tb_ir_nec_tx;

    localparam int U         = 4;
    localparam int CH        = 1;
    localparam int GU        = 2;
    localparam int FRAME_CYC = (121 + GU) * U;
`ifdef IR_TX_CARRIER_EN
    localparam bit CARRIER = 1'b1;
`else
    localparam bit CARRIER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] address;
    logic [7:0] command;
    logic       busy;
    logic       done;
    logic       ir_out;

    int n_cmp = 0;
    int n_bad = 0;

    bit exp_ir[$];
    bit cap[$];

    ir_nec_tx #(
        .UNIT_CYCLES (U),
        .CARRIER_HALF(CH),
        .GAP_UNITS   (GU)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .address(address),
        .command(command),
        .busy   (busy),
        .done   (done),
        .ir_out (ir_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_level(input bit mark, input int n);
        for (int k = 0; k < n; k++) begin
            if (!mark) exp_ir.push_back(1'b0);
            else if (CARRIER) exp_ir.push_back(((k / CH) % 2) == 0);
            else exp_ir.push_back(1'b1);
        end
    endtask

    task automatic build_expected(input logic [7:0] a, input logic [7:0] c);
        logic [31:0] f;
        f = {a, ~a, c, ~c};
        exp_ir.delete();
        push_level(1'b1, 16 * U);
        push_level(1'b0, 8 * U);
        for (int b = 31; b >= 0; b--) begin
            push_level(1'b1, U);
            push_level(1'b0, f[b] ? 3 * U : U);
        end
        push_level(1'b1, U);
        push_level(1'b0, GU * U);
    endtask

    function automatic logic [31:0] decode(input bit q[$]);
        int p;
        int z;
        logic [31:0] v;
        p = 0;
        v = '0;
        while (p < q.size() && q[p]) p++;
        while (p < q.size() && !q[p]) p++;
        for (int b = 0; b < 32; b++) begin
            while (p < q.size() && q[p]) p++;
            z = 0;
            while (p < q.size() && !q[p]) begin
                p++;
                z++;
            end
            v = {v[30:0], (z > 2 * U)};
        end
        return v;
    endfunction

    task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input bit keep_start,
                             input int pulse_at, input int reset_at, output bit aborted);
        int frame_bad;
        build_expected(a, c);
        cap.delete();
        frame_bad = 0;
        aborted   = 1'b0;
        address   = a;
        command   = c;
        start     = 1'b1;
        step();
        if (!keep_start) start = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            cap.push_back(ir_out);
            n_cmp++;
            if (ir_out !== exp_ir[i] || busy !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                if (frame_bad < 3)
                    $display("FAIL frame_wave cycle %0d: got ir_out=%b busy=%b done=%b, want ir_out=%b busy=1 done=0",
                             i, ir_out, busy, done, exp_ir[i]);
                frame_bad++;
            end
            if (keep_start) begin
                address = 8'($urandom);
                command = 8'($urandom);
            end
            if (pulse_at >= 0 && i == pulse_at) begin
                start   = 1'b1;
                address = 8'($urandom);
                command = 8'($urandom);
            end
            if (pulse_at >= 0 && i == pulse_at + 1) start = 1'b0;
            if (i == reset_at) begin
                reset = 1'b1;
                step();
                n_cmp++;
                if (ir_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_abort: got ir_out=%b busy=%b done=%b, want 0 0 0", ir_out, busy, done);
                end
                reset   = 1'b0;
                aborted = 1'b1;
                return;
            end
            step();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || ir_out !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_end: got done=%b busy=%b ir_out=%b, want done=1 busy=0 ir_out=0", done, busy, ir_out);
        end
    endtask

    task automatic check_idle_after(input string name);
        step();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || ir_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got done=%b busy=%b ir_out=%b, want 0 0 0", name, done, busy, ir_out);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        address = 8'h00;
        command = 8'h00;
        repeat (3) step();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++;
        if (ir_out !== 1'b0) begin n_bad++; $display("FAIL reset_ir_out: got %b want 0", ir_out); end
        reset = 1'b0;
        check_idle_after("idle_after_reset");
    endtask

    task automatic test_zero_frame();
        bit ab;
        run_frame(8'h00, 8'h00, 1'b0, -1, -1, ab);
        check_idle_after("zero_frame_after_done");
    endtask

    task automatic test_decode();
        bit ab;
        logic [7:0] a;
        logic [7:0] c;
        for (int f = 0; f < 5; f++) begin
            a = (f == 0) ? 8'hA5 : 8'($urandom);
            c = (f == 0) ? 8'h3C : 8'($urandom);
            run_frame(a, c, 1'b0, -1, -1, ab);
`ifndef IR_TX_CARRIER_EN
            n_cmp++;
            if (decode(cap) !== {a, ~a, c, ~c}) begin
                n_bad++;
                $display("FAIL decode: got %h want %h", decode(cap), {a, ~a, c, ~c});
            end
`endif
            check_idle_after("decode_after_done");
        end
    endtask

    task automatic test_ignored_start();
        bit ab;
        int extra;
        run_frame(8'($urandom), 8'($urandom), 1'b0, 100, -1, ab);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL ignored_start_extra: got %0d busy/done cycles after frame, want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        bit ab;
        int seen;
        run_frame(8'($urandom), 8'($urandom), 1'b0, -1, 200, ab);
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            if (done !== 1'b0 || busy !== 1'b0 || ir_out !== 1'b0) seen++;
            step();
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL reset_quiet: got %0d active cycles after reset, want 0", seen);
        end
        run_frame(8'($urandom), 8'($urandom), 1'b0, -1, -1, ab);
        check_idle_after("post_reset_frame_after_done");
    endtask

    task automatic test_back_to_back();
        bit ab;
        for (int f = 0; f < 3; f++) begin
            run_frame(8'($urandom), 8'($urandom), 1'b1, -1, -1, ab);
        end
        start = 1'b0;
        check_idle_after("b2b_after_last");
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_decode();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
